// File: rtl/wut_arb_pkg.sv
// Shared types and constants for the wake-up timer arbiter.
package wut_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  localparam int ACK_TIMEOUT_DEF = 8;

endpackage

// File: rtl/wut_arb_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module wut_arb_rr
  import wut_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  logic          found;
  logic [PW:0]   s;
  logic [PW-1:0] j;

  // walk NREQ positions starting at ptr_i, wrapping at NREQ
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr_i} + (PW+1)'(k);
      if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
      j = s[PW-1:0];
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/wut_arb.sv
// Arbitrates one wake-up timer among NREQ requesters.
// Optional macro WUT_ARB_TIMEOUT_EN adds START/RUN timeout with err pulse.
module wut_arb
  import wut_arb_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int NREQ        = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                  perm_clk,
  input  logic                  perm_rstb,
  input  logic [NREQ-1:0]       perm_arb_req,
  input  logic [NREQ*WIDTH-1:0] perm_arb_limit,
  input  logic [NREQ-1:0]       perm_arb_cancel,
  output logic [NREQ-1:0]       perm_arb_grant,
  output logic [NREQ-1:0]       perm_arb_done,
  output logic [NREQ-1:0]       perm_arb_err,
  output logic [WIDTH-1:0]      perm_wut_limit,
  output logic                  perm_wut_disable,
  output logic                  perm_wut_start_req,
  input  logic                  perm_wut_start_ack,
  input  logic                  perm_wut_trig_it
);

  localparam int PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             sreq_q, sreq_d, dis_q, dis_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  win;
  logic [PW-1:0]    win_idx;
  logic             owner_abort, start_to, run_to;

  wut_arb_rr #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i (perm_arb_req),
    .ptr_i (ptr_q),
    .gnt_o (win),
    .idx_o (win_idx)
  );

  // owner dropped its request or cancelled
  assign owner_abort = ~|(perm_arb_req & grant_q) | |(perm_arb_cancel & grant_q);

`ifdef WUT_ARB_TIMEOUT_EN
  localparam int RUN_LIM = (1 << WIDTH) + ACK_TIMEOUT;
  localparam int CW      = $clog2(RUN_LIM + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign start_to = (cnt_q == CW'(ACK_TIMEOUT - 1));
  assign run_to   = (cnt_q == CW'(RUN_LIM - 1));

  // cycles spent in the current START/RUN visit; restarts on state change
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && (state_q == S_START || state_q == S_RUN))
      cnt_d = cnt_q + 1'b1;
  end

  // timeout counter register
  always_ff @(posedge perm_clk or negedge perm_rstb) begin
    if (!perm_rstb) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign start_to = 1'b0;
  assign run_to   = 1'b0;
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    limit_d = limit_q;
    sreq_d  = sreq_q;
    dis_d   = 1'b0;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (|perm_arb_req) begin
          grant_d = win;
          limit_d = perm_arb_limit[int'(win_idx)*WIDTH +: WIDTH];
          sreq_d  = 1'b1;
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (owner_abort) begin
          sreq_d  = 1'b0;
          dis_d   = 1'b1;
          state_d = S_FLUSH;
        end else if (perm_wut_start_ack) begin
          sreq_d  = 1'b0;
          state_d = S_RUN;
        end else if (start_to) begin
          sreq_d  = 1'b0;
          dis_d   = 1'b1;
          err_d   = grant_q;
          state_d = S_FLUSH;
        end
      end
      S_RUN: begin
        // expiry beats a same-cycle cancel
        if (perm_wut_trig_it) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (owner_abort) begin
          dis_d   = 1'b1;
          state_d = S_FLUSH;
        end else if (run_to) begin
          dis_d   = 1'b1;
          err_d   = grant_q;
          state_d = S_FLUSH;
        end
      end
      S_DONE, S_FLUSH: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        sreq_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers; timer held disabled while in reset
  always_ff @(posedge perm_clk or negedge perm_rstb) begin
    if (!perm_rstb) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      limit_q <= '0;
      sreq_q  <= 1'b0;
      dis_q   <= 1'b1;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      limit_q <= limit_d;
      sreq_q  <= sreq_d;
      dis_q   <= dis_d;
      ptr_q   <= ptr_d;
    end
  end

  assign perm_arb_grant     = grant_q;
  assign perm_arb_done      = done_q;
  assign perm_arb_err       = err_q;
  assign perm_wut_limit     = limit_q;
  assign perm_wut_disable   = dis_q;
  assign perm_wut_start_req = sreq_q;

endmodule

// File: tb/tb_wut_arb.sv
// Randomized + directed bench for wut_arb with a cycle-level reference model.
module tb_wut_arb;
  localparam int W  = 9;
  localparam int N  = 4;
  localparam int AT = 8;
  localparam int LW = N * W;

  logic          clk = 1'b0, rstb = 1'b1;
  logic [N-1:0]  req = '0, cancel = '0;
  logic [LW-1:0] lim = '0;
  logic          ack = 1'b0, trig = 1'b0;
  logic [N-1:0]  grant, done, err;
  logic [W-1:0]  wlim;
  logic          dis, sreq;

  wut_arb #(.WIDTH(W), .NREQ(N), .ACK_TIMEOUT(AT)) dut (
    .perm_clk           (clk),
    .perm_rstb          (rstb),
    .perm_arb_req       (req),
    .perm_arb_limit     (lim),
    .perm_arb_cancel    (cancel),
    .perm_arb_grant     (grant),
    .perm_arb_done      (done),
    .perm_arb_err       (err),
    .perm_wut_limit     (wlim),
    .perm_wut_disable   (dis),
    .perm_wut_start_req (sreq),
    .perm_wut_start_ack (ack),
    .perm_wut_trig_it   (trig)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phase 0 idle,1 waiting ack,2 timing,3 done,4 flush
  int m_ph, m_own, m_ptr, m_cnt;
  bit m_abort;
  logic [N-1:0] e_grant, e_done, e_err;
  logic [W-1:0] e_lim;
  logic         e_dis, e_sreq;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_ph = 0; m_own = -1; m_ptr = 0; m_cnt = 0;
      e_grant = '0; e_done = '0; e_err = '0; e_lim = '0; e_dis = 1'b1; e_sreq = 1'b0;
    end else begin
      e_done = '0;
      e_err  = '0;
      m_abort = (m_own >= 0) && (!req[m_own] || cancel[m_own]);
      case (m_ph)
        0: begin
          e_dis = 1'b0;
          if (req != '0) begin
            m_own = -1;
            for (int k = 0; k < N; k++)
              if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
            e_grant = '0;
            e_grant[m_own] = 1'b1;
            e_lim  = lim[m_own*W +: W];
            e_sreq = 1'b1;
            m_ptr  = (m_own + 1) % N;
            m_cnt  = 0;
            m_ph   = 1;
          end
        end
        1: begin
          if (m_abort) begin
            e_dis = 1'b1; e_sreq = 1'b0; m_ph = 4;
          end else if (ack) begin
            e_sreq = 1'b0; m_cnt = 0; m_ph = 2;
          end else begin
            m_cnt++;
`ifdef WUT_ARB_TIMEOUT_EN
            if (m_cnt >= AT) begin
              e_dis = 1'b1; e_sreq = 1'b0; e_err = e_grant; m_ph = 4;
            end
`endif
          end
        end
        2: begin
          if (trig) begin
            e_done = e_grant; m_ph = 3;
          end else if (m_abort) begin
            e_dis = 1'b1; m_ph = 4;
          end else begin
            m_cnt++;
`ifdef WUT_ARB_TIMEOUT_EN
            if (m_cnt >= (1 << W) + AT) begin
              e_dis = 1'b1; e_err = e_grant; m_ph = 4;
            end
`endif
          end
        end
        default: begin
          e_grant = '0; e_dis = 1'b0; m_own = -1; m_ph = 0;
        end
      endcase
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_on) begin
      chk("m_grant", grant, e_grant);
      chk("m_done",  done,  e_done);
      chk("m_err",   err,   e_err);
      chk("m_limit", wlim,  e_lim);
      chk("m_dis",   dis,   e_dis);
      chk("m_sreq",  sreq,  e_sreq);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rstb = 1'b0;
    mon_on = 1'b1;
    req = '0; cancel = '0; ack = 1'b0; trig = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_dis", dis, 1);
    chk("rst_limit", wlim, 0);
    chk("rst_sreq", sreq, 0);
    #2 rstb = 1'b1;
    @(negedge clk);
    chk("rst_dis_release", dis, 0);
  endtask

  task automatic wait_sreq();
    int n = 0;
    @(negedge clk);
    while (!sreq && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sreq_wait", sreq, 1);
  endtask

  task automatic txn(input logic [N-1:0] eg);
    wait_sreq();
    chk("txn_grant", grant, eg);
    ack = 1'b1;
    @(negedge clk);
    chk("txn_sreq_low", sreq, 0);
    trig = 1'b1;
    @(negedge clk);
    chk("txn_done", done, eg);
    ack = 1'b0; trig = 1'b0;
    @(negedge clk);
    chk("txn_done_clr", done, 0);
  endtask

  initial begin
    logic [N-1:0] eg;
    do_reset();

    // single requester 1, limit 5; owner limit change after grant ignored
    lim = {9'd3, 9'd11, 9'd5, 9'd7};
    req = 4'b0010;
    wait_sreq();
    chk("r36_grant", grant, 4'b0010);
    chk("r36_limit", wlim, 5);
    lim[W +: W] = 9'd200;
    ack = 1'b1;
    @(negedge clk);
    chk("r36_sreq_1cyc", sreq, 0);
    chk("r36_limit_hold", wlim, 5);
    trig = 1'b1;
    @(negedge clk);
    chk("r36_done", done, 4'b0010);
    ack = 1'b0; trig = 1'b0; req = '0;
    @(negedge clk);
    chk("r36_grant_clr", grant, 0);

    // all four held: strict rotation from index 0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      txn(eg);
    end
    req = '0;
    @(negedge clk);

    // cancel during RUN: one disable cycle, no done
    do_reset();
    req = 4'b0001;
    wait_sreq();
    ack = 1'b1;
    @(negedge clk);
    cancel = 4'b0001;
    @(negedge clk);
    chk("r38_dis", dis, 1);
    chk("r38_done", done, 0);
    cancel = '0; req = '0; ack = 1'b0;
    @(negedge clk);
    chk("r38_dis_1cyc", dis, 0);
    chk("r38_grant_clr", grant, 0);

    // expiry and cancel together: expiry wins
    do_reset();
    req = 4'b0001;
    wait_sreq();
    ack = 1'b1;
    @(negedge clk);
    trig = 1'b1; cancel = 4'b0001;
    @(negedge clk);
    chk("r39_done", done, 4'b0001);
    chk("r39_dis", dis, 0);
    trig = 1'b0; cancel = '0; ack = 1'b0; req = '0;
    @(negedge clk);

    // ack never returned
    do_reset();
    req = 4'b0001;
    wait_sreq();
`ifdef WUT_ARB_TIMEOUT_EN
    for (int i = 0; i < AT - 1; i++) begin
      @(negedge clk);
      chk("r40_err_early", err, 0);
    end
    @(negedge clk);
    chk("r40_err", err, 4'b0001);
    chk("r40_dis", dis, 1);
`else
    repeat (20) @(negedge clk);
    chk("r40_hold_sreq", sreq, 1);
    chk("r40_hold_grant", grant, 4'b0001);
    chk("r40_err", err, 0);
`endif
    req = '0;
    @(negedge clk);

    // reset in RUN
    do_reset();
    req = 4'b0001;
    wait_sreq();
    ack = 1'b1;
    @(negedge clk);
    #2 rstb = 1'b0;
    trig = 1'b1;
    #1;
    chk("r41_grant", grant, 0);
    chk("r41_dis", dis, 1);
    chk("r41_done", done, 0);
    chk("r41_sreq", sreq, 0);
    chk("r41_limit", wlim, 0);
    @(negedge clk);
    chk("r41_done_hold", done, 0);
    trig = 1'b0;
    do_reset();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        cancel[i] = ($urandom_range(15) == 0);
      end
      ack  = $urandom_range(1) == 1;
      trig = $urandom_range(3) == 0;
      if ($urandom_range(15) == 0) lim = LW'({$urandom, $urandom});
      if ($urandom_range(999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wut_arb.md
WUT_ARB -- requirements
Module: wut_arb

Interface
REQ-001 Parameter WIDTH, default 9: wake-up timer limit width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the wake-up timer (2..8).
REQ-003 Parameter ACK_TIMEOUT, default 8: cycles allowed for timer start acknowledge.
REQ-004 perm_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 perm_rstb  input  1  asynchronous active-low reset.
REQ-006 perm_arb_req  input  NREQ  level request per requester, held until done or cancel.
REQ-007 perm_arb_limit  input  NREQ*WIDTH  per-requester limit; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 perm_arb_cancel  input  NREQ  per-requester abort, effective only for the granted requester.
REQ-009 perm_arb_grant  output  NREQ  one-hot owner of the timer; all-zero when idle.
REQ-010 perm_arb_done  output  NREQ  one-cycle pulse to the owner on timer expiry.
REQ-011 perm_arb_err  output  NREQ  one-cycle pulse to the owner on timeout abort (macro only, else tied 0).
REQ-012 perm_wut_limit  output  WIDTH  limit driven to the timer, latched at grant.
REQ-013 perm_wut_disable  output  1  timer force-stop.
REQ-014 perm_wut_start_req  output  1  timer start request.
REQ-015 perm_wut_start_ack  input  1  timer acknowledge, high while timer counts.
REQ-016 perm_wut_trig_it  input  1  timer expiry event.

Function
REQ-017 FSM states IDLE, START, RUN, DONE, FLUSH; all outputs registered.
REQ-018 IDLE: if any perm_arb_req bit set, grant winner by round-robin, latch its limit, go START; else stay.
REQ-019 Round-robin: search starts at index (last winner + 1) mod NREQ; pointer after reset = 0 (index 0 highest).
REQ-020 Latency: req high sampled in IDLE at edge t -> grant and start_req high after edge t.
REQ-021 START: start_req held high until start_ack sampled high, then start_req low, go RUN.
REQ-022 RUN: trig_it high -> go DONE; done pulse for owner asserted in DONE cycle.
REQ-023 DONE: one cycle; grant cleared on exit; go IDLE; re-arbitration occurs in IDLE only.
REQ-024 Owner req low or cancel high in START or RUN -> go FLUSH; no done pulse.
REQ-025 FLUSH: disable high exactly one cycle, start_req low, grant cleared on exit, go IDLE.
REQ-026 trig_it and cancel high in the same RUN cycle: trig_it wins, done pulses.
REQ-027 Requests and limits of non-owners are ignored while not IDLE; limit changes of owner after grant are ignored.
REQ-028 Limit 0 is legal: handled as any other value (timer expires immediately).
REQ-029 At most one bit of grant, done, err set in any cycle.

Reset
REQ-030 Reset: state IDLE, RR pointer 0, grant/done/err 0, start_req 0, disable 1, limit 0.
REQ-031 disable deasserts on the first clock edge after reset release; reset mid-operation aborts silently with no done/err.

Configuration
REQ-032 Macro WUT_ARB_TIMEOUT_EN defined: START exceeding ACK_TIMEOUT cycles, or RUN exceeding 2^WIDTH+ACK_TIMEOUT cycles -> FLUSH plus one-cycle err pulse to the owner.
REQ-033 Macro undefined: no timeout counter present; START/RUN wait indefinitely; perm_arb_err constant 0.

Structure
REQ-034 Package wut_arb_pkg holds FSM state encoding and default ACK_TIMEOUT constant.
REQ-035 Sub-module wut_arb_rr: combinational round-robin picker (req vector, pointer -> one-hot winner).

Verification
REQ-036 Single req[1], limit 5, model timer acks after 1 cycle -> grant=0010, start_req 1 cycle, done[1] pulse after trig, grant 0.
REQ-037 req=1111 held continuously -> grants sequence 0001,0010,0100,1000,0001, one done each.
REQ-038 Owner cancels in RUN -> disable high exactly one cycle, no done, IDLE next cycle.
REQ-039 trig_it and cancel same cycle -> done pulses, no disable.
REQ-040 WUT_ARB_TIMEOUT_EN defined, ack never returned -> err pulse after 8 START cycles, disable 1 cycle; macro undefined -> FSM stays in START.
REQ-041 Reset asserted in RUN -> all outputs at reset values, disable 1, no done/err pulse.
